// File: rtl/instr_sequencer.sv
// -----------------------------------------------------------------------------
// instr_sequencer
//   Multi-cycle control FSM for the RISC core. It steps each instruction
//   through FETCH -> DECODE -> EXEC -> (MEM) -> WB. It owns the PC and the
//   {N,Z,C} flags register, drives the imem/dmem request handshakes, resolves
//   branches and produces the link value for bl.
//
//   Optional feature macro: SEQ_WATCHDOG_EN
//     When it is defined, the sequencer stops waiting for imem_ack/dmem_ack
//     after TIMEOUT cycles. It then enters a sticky FAULT state with fault=1.
//     When it is not defined, the sequencer waits for an ack without limit and
//     fault is tied to 0.
//
// Parameters
//   ADDR_W    PC / address width
//   RESET_PC  PC value loaded on reset
//   TIMEOUT   ack-wait limit in cycles (SEQ_WATCHDOG_EN only)
//
// Ports
//   clk, rst                     clock; synchronous active-high reset
//   run                          level; allows a new fetch (sampled in IDLE/WB)
//   imem_req/imem_addr/imem_ack  instruction fetch handshake (addr = pc)
//   branch, function_code        decoder branch class and function code
//   is_mem, is_halt, flag_we,
//   wb_en                        decoder instruction attributes
//   alu_neg/alu_zero/alu_carry   ALU flags, valid in EXEC
//   reg1_value, branch_address   register / immediate branch targets
//   dmem_req/dmem_ack            data memory handshake
//   reg_we, link_we, link_value  write-back strobes and the bl link value
//   pc, flags                    architectural PC and {N,Z,C}
//   halted, fault                sticky HALT / watchdog FAULT indicators
// -----------------------------------------------------------------------------
module instr_sequencer #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                TIMEOUT  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [1:0]        branch,
  input  logic [5:0]        function_code,
  input  logic              is_mem,
  input  logic              is_halt,
  input  logic              flag_we,
  input  logic              wb_en,
  input  logic              alu_neg,
  input  logic              alu_zero,
  input  logic              alu_carry,
  input  logic [31:0]       reg1_value,
  input  logic [ADDR_W-1:0] branch_address,
  output logic              dmem_req,
  input  logic              dmem_ack,
  output logic              reg_we,
  output logic              link_we,
  output logic [ADDR_W-1:0] link_value,
  output logic [ADDR_W-1:0] pc,
  output logic [2:0]        flags,
  output logic              halted,
  output logic              fault
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
`ifdef SEQ_WATCHDOG_EN
    , S_FAULT
`endif
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pc_next_q, pc_next_d;  // branch outcome, captured in EXEC
  logic [2:0]        flags_q, flags_d;      // {N,Z,C}

  logic [ADDR_W-1:0] seq_pc;
  logic [ADDR_W-1:0] resolved_pc;
  logic              flag_n, flag_z, flag_c;

  assign seq_pc = pc_q + ADDR_W'(1);  // wraps modulo 2^ADDR_W
  assign flag_n = flags_q[2];
  assign flag_z = flags_q[1];
  assign flag_c = flags_q[0];

  // The branch decision reads the registered flags. An instruction that also
  // sets flags therefore branches on the flags that were valid before it.
  always_comb begin
    resolved_pc = seq_pc;
    unique case (branch)
      2'b01: begin
        unique case (function_code)
          6'd0:    resolved_pc = reg1_value[ADDR_W-1:0];
          6'd1:    resolved_pc = flag_n  ? branch_address : seq_pc;
          6'd2:    resolved_pc = flag_z  ? branch_address : seq_pc;
          6'd3:    resolved_pc = !flag_z ? branch_address : seq_pc;
          default: resolved_pc = seq_pc;
        endcase
      end
      2'b10: begin
        unique case (function_code)
          6'd0:    resolved_pc = branch_address;
          6'd1:    resolved_pc = flag_c  ? branch_address : seq_pc;
          6'd2:    resolved_pc = !flag_c ? branch_address : seq_pc;
          default: resolved_pc = seq_pc;
        endcase
      end
      2'b11:   resolved_pc = branch_address;
      default: resolved_pc = seq_pc;
    endcase
  end

`ifdef SEQ_WATCHDOG_EN
  localparam int                WD_W    = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0]   WD_LAST = WD_W'(TIMEOUT - 1);

  logic [WD_W-1:0] wd_q, wd_d;
  logic            wd_expired;

  // The counter only runs while waiting for an ack. It is held at zero in
  // every other state, so each entry to FETCH/MEM starts a fresh count.
  always_comb begin
    wd_d = '0;
    if ((state_q == S_FETCH && !imem_ack) || (state_q == S_MEM && !dmem_ack))
      wd_d = wd_q + WD_W'(1);
  end

  assign wd_expired = (wd_q == WD_LAST);

  always_ff @(posedge clk) begin
    if (rst) wd_q <= '0;
    else     wd_q <= wd_d;
  end
`endif

  // Next-state logic and outputs.
  always_comb begin
    // NOTE: give every output of a combinational block a value before the
    // case statement. If any path leaves a signal unassigned, synthesis
    // infers a latch.
    state_d    = state_q;
    pc_d       = pc_q;
    pc_next_d  = pc_next_q;
    flags_d    = flags_q;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    reg_we     = 1'b0;
    link_we    = 1'b0;
    halted     = 1'b0;
    fault      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // A late imem_ack arriving here, for example after a reset that cut a
        // fetch short, has no effect.
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) state_d = S_DECODE;
`ifdef SEQ_WATCHDOG_EN
        else if (wd_expired) state_d = S_FAULT;
`endif
      end
      S_DECODE: begin
        state_d = is_halt ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        pc_next_d = resolved_pc;
        if (flag_we) flags_d = {alu_neg, alu_zero, alu_carry};
        state_d = is_mem ? S_MEM : S_WB;
      end
      S_MEM: begin
        dmem_req = 1'b1;
        if (dmem_ack) state_d = S_WB;
`ifdef SEQ_WATCHDOG_EN
        else if (wd_expired) state_d = S_FAULT;
`endif
      end
      S_WB: begin
        reg_we  = wb_en;
        link_we = (branch == 2'b11);
        pc_d    = pc_next_q;
        state_d = run ? S_FETCH : S_IDLE;
      end
      S_HALT: begin
        halted = 1'b1;  // sticky until rst; pc stays at the halt instruction
      end
`ifdef SEQ_WATCHDOG_EN
      S_FAULT: begin
        fault = 1'b1;   // sticky until rst; all requests and strobes stay low
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments so that
  // every register samples the values from before the clock edge, whatever
  // order the statements appear in.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      pc_next_q <= RESET_PC;
      flags_q   <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pc_next_q <= pc_next_d;
      flags_q   <= flags_d;
    end
  end

  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign flags      = flags_q;
  assign link_value = seq_pc;  // pc+1; only meaningful while link_we is high

endmodule
